// File: rtl/lcd_text_queue_if.sv
// Bus between a text producer, the character queue and the LCD controller.
// The slave modport is the queue itself; the master modport is whoever
// feeds characters and models the controller's busy flag.
interface lcd_text_queue_if #(
    parameter int DEPTH = 32
);
    logic                     wr_en;
    logic [7:0]               wr_data;
    logic                     wr_wait;
    logic                     lcd_status;
    logic                     lcd_wen;
    logic [8:0]               lcd_wdt;
    logic [$clog2(DEPTH):0]   level;
    logic                     init_done;

    modport master (
        output wr_en, wr_data, lcd_status,
        input  wr_wait, lcd_wen, lcd_wdt, level, init_done
    );

    modport slave (
        input  wr_en, wr_data, lcd_status,
        output wr_wait, lcd_wen, lcd_wdt, level, init_done
    );
endinterface

// File: rtl/lcd_text_queue.sv
// Character FIFO in front of an HD44780-style LCD controller. After reset
// it issues the power-up command sequence, then drains the FIFO, turning
// printable characters, newline and form feed into data/command writes and
// tracking the cursor so line wraps get a set-address command.
module lcd_text_queue #(
    parameter int DEPTH = 32,
    parameter int COLS  = 16,
    parameter int ROWS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    lcd_text_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {INIT, IDLE, EXPAND} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [LW-1:0]   level_q;
    logic [2:0]      init_idx, init_idx_nxt;
    logic [1:0]      row, row_nxt;
    logic [5:0]      col, col_nxt;
    logic            init_done_q;
    logic            wen_q;
    logic [8:0]      wdt_q;

    logic            slot, push, pop, strobe;
    logic [8:0]      cmd;
    logic [7:0]      head;

    function automatic logic [8:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return 9'h038;
            3'd1:    return 9'h00C;
            3'd2:    return 9'h001;
            3'd3:    return 9'h006;
            default: return 9'h080;
        endcase
    endfunction

    // Set-DDRAM-address command for a cursor position.
    function automatic logic [8:0] set_addr(input logic [1:0] r, input logic [5:0] c);
        logic [6:0] base;
        case (r)
            2'd0:    base = 7'h00;
            2'd1:    base = 7'h40;
            2'd2:    base = 7'h14;
            default: base = 7'h54;
        endcase
        return {2'b01, base + {1'b0, c}};
    endfunction

    function automatic logic [1:0] next_row(input logic [1:0] r);
        return (r == 2'(ROWS - 1)) ? 2'd0 : r + 2'd1;
    endfunction

    assign head = mem[rd_ptr];
    // A strobe may only follow an idle cycle with the controller ready.
    assign slot = !bus.lcd_status && !wen_q;
    assign push = bus.wr_en && (level_q != LW'(DEPTH));

    // Next-state, cursor update and command selection; init beats expansion
    // beats the FIFO head because the states make them mutually exclusive.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_nxt    = state;
        init_idx_nxt = init_idx;
        row_nxt      = row;
        col_nxt      = col;
        strobe       = 1'b0;
        pop          = 1'b0;
        cmd          = wdt_q;
        case (state)
            INIT: begin
                if (slot) begin
                    strobe = 1'b1;
                    cmd    = init_cmd(init_idx);
                    if (init_idx == 3'd4) begin
                        state_nxt    = IDLE;
                        init_idx_nxt = 3'd0;
                    end else begin
                        init_idx_nxt = init_idx + 3'd1;
                    end
                end
            end
            EXPAND: begin
                // Cursor already points at the new line start.
                if (slot) begin
                    strobe    = 1'b1;
                    cmd       = set_addr(row, col);
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (slot && level_q != '0) begin
                    pop = 1'b1;
                    if (head >= 8'h20 && head <= 8'h7E) begin
                        strobe = 1'b1;
                        cmd    = {1'b1, head};
                        if (col == 6'(COLS - 1)) begin
                            col_nxt   = 6'd0;
                            row_nxt   = next_row(row);
                            state_nxt = EXPAND;
                        end else begin
                            col_nxt = col + 6'd1;
                        end
                    end else if (head == 8'h0A) begin
                        strobe  = 1'b1;
                        cmd     = set_addr(next_row(row), 6'd0);
                        row_nxt = next_row(row);
                        col_nxt = 6'd0;
                    end else if (head == 8'h0C) begin
                        strobe    = 1'b1;
                        cmd       = 9'h001;
                        row_nxt   = 2'd0;
                        col_nxt   = 6'd0;
                        state_nxt = EXPAND;
                    end
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential logic uses non-blocking assignments so every register sees pre-edge values.
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    // Pointers, occupancy, cursor and LCD output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level_q     <= '0;
            init_idx    <= 3'd0;
            row         <= 2'd0;
            col         <= 6'd0;
            wen_q       <= 1'b0;
            wdt_q       <= 9'h000;
            init_done_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);
            init_idx    <= init_idx_nxt;
            row         <= row_nxt;
            col         <= col_nxt;
            wen_q       <= strobe;
            if (strobe) wdt_q <= cmd;
            // Leaving INIT means the 0x080 strobe is on the bus this cycle.
            init_done_q <= init_done_q | (state != INIT);
        end
    end

    // Character storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the reset pointers and level make stale entries unreachable.
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    assign bus.wr_wait   = (level_q == LW'(DEPTH));
    assign bus.level     = level_q;
    assign bus.lcd_wen   = wen_q;
    assign bus.lcd_wdt   = wdt_q;
    assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_lcd_text_queue.sv
// Self-checking bench for lcd_text_queue: expected LCD strobes go into a
// scoreboard queue as stimulus is driven and are compared as they appear.
module tb_lcd_text_queue;
    localparam int DEPTH = 32;
    localparam int COLS  = 16;
    localparam int ROWS  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_text_queue_if #(.DEPTH(DEPTH)) bus ();

    lcd_text_queue #(.DEPTH(DEPTH), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_q [$];
    logic prev_wen = 1'b0;

    typedef struct {
        string      name;
        logic [7:0] ch;
        int         n;
        logic [8:0] e0;
        logic [8:0] e1;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every strobe must match the oldest owed command.
    always @(negedge clk) begin
        if (bus.lcd_wen === 1'b1) begin
            check("wen_gap", {31'b0, prev_wen}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got 0x%0h, expected no strobe", bus.lcd_wdt);
            end else begin
                check("strobe", {23'b0, bus.lcd_wdt}, {23'b0, exp_q.pop_front()});
            end
        end
        prev_wen = (bus.lcd_wen === 1'b1);
    end

    task automatic push(input logic [7:0] c);
        bus.wr_en   = 1'b1;
        bus.wr_data = c;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s: timeout, got %0d strobes still owed, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h080);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int found;
        logic [7:0] c;

        vecs[0]  = '{"char_A",     8'h41, 1, 9'h141, 9'h000};
        vecs[1]  = '{"char_B",     8'h42, 1, 9'h142, 9'h000};
        vecs[2]  = '{"newline_r1", 8'h0A, 1, 9'h0C0, 9'h000};
        vecs[3]  = '{"bell_drop",  8'h07, 0, 9'h000, 9'h000};
        vecs[4]  = '{"char_Z",     8'h5A, 1, 9'h15A, 9'h000};
        vecs[5]  = '{"formfeed",   8'h0C, 2, 9'h001, 9'h080};
        vecs[6]  = '{"newline_r1", 8'h0A, 1, 9'h0C0, 9'h000};
        vecs[7]  = '{"newline_r0", 8'h0A, 1, 9'h080, 9'h000};
        vecs[8]  = '{"char_tilde", 8'h7E, 1, 9'h17E, 9'h000};
        vecs[9]  = '{"char_space", 8'h20, 1, 9'h120, 9'h000};
        vecs[10] = '{"del_drop",   8'h7F, 0, 9'h000, 9'h000};
        vecs[11] = '{"ctl_drop",   8'h1F, 0, 9'h000, 9'h000};
        vecs[12] = '{"formfeed",   8'h0C, 2, 9'h001, 9'h080};

        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_data    = 8'h00;
        bus.lcd_status = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_wen",       {31'b0, bus.lcd_wen},   32'd0);
        check("rst_wdt",       {23'b0, bus.lcd_wdt},   32'd0);
        check("rst_level",     {26'b0, bus.level},     32'd0);
        check("rst_init_done", {31'b0, bus.init_done}, 32'd0);
        check("rst_wr_wait",   {31'b0, bus.wr_wait},   32'd0);

        // Init sequence on alternate cycles; 0x080 lands on the 9th cycle.
        expect_init();
        rst = 1'b0;
        found = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.lcd_wen === 1'b1 && bus.lcd_wdt === 9'h080) begin
                found = i;
                break;
            end
        end
        check("init_last_cycle", found, 32'd9);
        check("init_done_low_at_strobe", {31'b0, bus.init_done}, 32'd0);
        @(negedge clk);
        check("init_done_rise", {31'b0, bus.init_done}, 32'd1);
        drain("init");

        // Single-character vectors from a known cursor position.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].n > 0) exp_q.push_back(vecs[i].e0);
            if (vecs[i].n > 1) exp_q.push_back(vecs[i].e1);
            push(vecs[i].ch);
            drain(vecs[i].name);
            check({vecs[i].name, "_level"}, {26'b0, bus.level}, 32'd0);
        end

        // Column wrap: 17 'x' from (0,0) on a 16-column display.
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(9'h178);
            if (i == COLS - 1) exp_q.push_back(9'h0C0);
        end
        for (int i = 0; i < 17; i++) push(8'h78);
        drain("col_wrap");
        check("col_wrap_level", {26'b0, bus.level}, 32'd0);

        // Form feed, discarded bell, then a character, back to back.
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h080);
        exp_q.push_back(9'h15A);
        push(8'h0C);
        push(8'h07);
        push(8'h5A);
        drain("ff_bell_Z");

        // Home the cursor, then fill the FIFO while the controller is busy.
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h080);
        push(8'h0C);
        drain("home");
        bus.lcd_status = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            c = 8'h61 + 8'(i % 26);
            exp_q.push_back({1'b1, c});
            if (i == COLS - 1)     exp_q.push_back(9'h0C0);
            if (i == 2 * COLS - 1) exp_q.push_back(9'h080);
            push(c);
        end
        check("full_level",   {26'b0, bus.level},   DEPTH);
        check("full_wr_wait", {31'b0, bus.wr_wait}, 32'd1);
        push(8'h21);
        check("full_drop_level", {26'b0, bus.level}, DEPTH);
        bus.lcd_status = 1'b0;
        drain("full_drain");
        check("full_empty_level", {26'b0, bus.level},   32'd0);
        check("full_empty_wait",  {31'b0, bus.wr_wait}, 32'd0);
        check("wdt_hold",         {23'b0, bus.lcd_wdt}, 32'h080);

        // Reset while waiting in EXPAND with five entries queued.
        bus.lcd_status = 1'b1;
        push(8'h0C);
        push(8'h68);
        push(8'h65);
        push(8'h6C);
        push(8'h6C);
        push(8'h6F);
        exp_q.push_back(9'h001);
        bus.lcd_status = 1'b0;
        @(negedge clk);
        bus.lcd_status = 1'b1;
        @(negedge clk);
        check("expand_wait_level", {26'b0, bus.level},   32'd5);
        check("expand_wait_wen",   {31'b0, bus.lcd_wen}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_level",     {26'b0, bus.level},     32'd0);
        check("midrst_wen",       {31'b0, bus.lcd_wen},   32'd0);
        check("midrst_init_done", {31'b0, bus.init_done}, 32'd0);
        @(negedge clk);
        bus.lcd_status = 1'b0;
        expect_init();
        rst = 1'b0;
        drain("reinit");
        check("reinit_done",  {31'b0, bus.init_done}, 32'd1);
        check("reinit_level", {26'b0, bus.level},     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lcd_text_queue.md
LCD_TEXT_QUEUE -- requirements
Module: lcd_text_queue

Interface
REQ-001 Parameter DEPTH, default 32, character FIFO entries; power of two, 4..256.
REQ-002 Parameter COLS, default 16, display columns per row; 8..40.
REQ-003 Parameter ROWS, default 2, display rows; 1, 2 or 4.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  push request for wr_data.
REQ-007 wr_data  in  8  ASCII character or control code.
REQ-008 wr_wait  out  1  FIFO full; pushes refused while high.
REQ-009 lcd_status  in  1  LCD controller busy.
REQ-010 lcd_wen  out  1  one-cycle write strobe to LCD controller.
REQ-011 lcd_wdt  out  9  {RS, byte}; RS=0 command, RS=1 data; valid when lcd_wen=1.
REQ-012 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 init_done  out  1  high once the init sequence has been fully issued.

Function
REQ-014 FIFO: circular buffer, read/write pointers, no shifting; push accepted iff wr_en=1 and level<DEPTH.
REQ-015 wr_wait = (level==DEPTH), combinational from level only; a push in a full cycle is dropped even if a pop occurs in the same cycle.
REQ-016 Simultaneous accepted push and pop: level unchanged, both pointers advance.
REQ-017 Pointers wrap modulo DEPTH; level never exceeds DEPTH, never underflows.
REQ-018 Init sequence, issued in order after reset before any FIFO entry: 0x038, 0x00C, 0x001, 0x006, 0x080.
REQ-019 init_done rises in the cycle after the lcd_wen pulse carrying 0x080.
REQ-020 Issue rule: lcd_wen=1 in cycle t+1 iff in cycle t lcd_status=0, lcd_wen=0, and a command is pending; lcd_wen never high on two consecutive cycles.
REQ-021 Pending priority: init step > expansion step > FIFO head.
REQ-022 FSM states: INIT, IDLE, EXPAND; INIT->IDLE after the last init command issues; IDLE->EXPAND when a popped code needs a second command; EXPAND->IDLE when its command issues.
REQ-023 FIFO pop occurs in the same cycle lcd_wen asserts for the head entry; entries pushed in cycle N are eligible for issue no earlier than cycle N+1.
REQ-024 Cursor state: row 0..ROWS-1, col 0..COLS-1; both 0 after init.
REQ-025 Row base address: row0 0x00, row1 0x40, row2 0x14, row3 0x54; set-address command = {1'b0, 0x80 | (base+col)}.
REQ-026 Printable 0x20..0x7E: issue {1'b1, code}; col+1.
REQ-027 Column wrap: if col+1==COLS, col<=0, row<=(row+1) mod ROWS, then EXPAND issues set-address for the new row.
REQ-028 0x0A newline: issue set-address for ((row+1) mod ROWS, col 0); no second command.
REQ-029 0x0C form feed: issue 0x001, then EXPAND issues 0x080; row=col=0.
REQ-030 All other codes: popped and discarded; no lcd_wen; pop uses the same issue slot without strobing.
REQ-031 lcd_wdt holds its last value when lcd_wen=0.

Reset
REQ-032 rst=1 at a rising edge: lcd_wen=0, lcd_wdt=0, level=0, init_done=0, pointers=0, row=col=0, state=INIT.
REQ-033 Reset mid-operation aborts any pending expansion and discards FIFO contents; init restarts from 0x038 after release.
REQ-034 No output depends on reset asynchronously.

Verification
REQ-035 Release reset, lcd_status=0 -> lcd_wen pulses on alternate cycles with 0x038,0x00C,0x001,0x006,0x080; init_done=1 afterwards.
REQ-036 After init, push "AB" -> lcd_wdt 0x141, 0x142; level returns to 0.
REQ-037 COLS=16, push 17 x 'x' -> 16 data writes, then 0x0C0, then 0x178.
REQ-038 lcd_status held 1, push 32 chars -> level=32, wr_wait=1, 33rd push dropped; release status -> 32 writes in order.
REQ-039 Push 0x0C then 0x07 then 'Z' -> 0x001, 0x080, 0x15A; 0x07 produces no strobe.
REQ-040 Assert rst during an EXPAND wait with level=5 -> level=0, lcd_wen=0; after release, 0x038 is the first strobe.
